edge_event_arbiter: RTL and testbench

EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

---
 rtl/edge_event_arbiter_if.sv | 45 ++++
 rtl/edge_event_arbiter.sv | 175 +++++++++++++++++
 tb/tb_edge_event_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/edge_event_arbiter_if.sv
// Bundle between the edge event arbiter and its environment.
//
// Signals:
//   in           raw, asynchronous, bouncing channel inputs.
//   evt_valid    output event register holds an event.
//   evt_id       channel index of the held event.
//   evt_rise     polarity of the held event (1 = rising, 0 = falling).
//   evt_ready    consumer accepts the held event.
//   pending      per-channel event captured, not yet in the output register.
//   overflow     sticky per-channel dropped-event flag.
//   clr_overflow per-bit synchronous clear of overflow.
//   dbg_state    packed debounce FSM state, 2 bits per channel.
//   dbg_rr_ptr   round-robin pointer.
//
// Handshake: an event transfers on a rising clk edge where evt_valid and
// evt_ready are both 1. evt_valid never depends on evt_ready, and evt_id and
// evt_rise hold stable while evt_valid=1 and evt_ready=0.
//
// Modports: master = the arbiter, slave = the event consumer.
interface edge_event_arbiter_if #(
    parameter int N = 4
);
    localparam int ID_W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]    in;
    logic            evt_valid;
    logic [ID_W-1:0] evt_id;
    logic            evt_rise;
    logic            evt_ready;
    logic [N-1:0]    pending;
    logic [N-1:0]    overflow;
    logic [N-1:0]    clr_overflow;
    logic [2*N-1:0]  dbg_state;
    logic [ID_W-1:0] dbg_rr_ptr;

    modport master (
        input  in, evt_ready, clr_overflow,
        output evt_valid, evt_id, evt_rise, pending, overflow, dbg_state, dbg_rr_ptr
    );

    modport slave (
        output in, evt_ready, clr_overflow,
        input  evt_valid, evt_id, evt_rise, pending, overflow, dbg_state, dbg_rr_ptr
    );
endinterface

// File: rtl/edge_event_arbiter.sv
// Edge event arbiter: synchronizes N bouncing inputs, debounces each with an
// early-detect lockout FSM, queues one rise/fall event per channel and hands
// events to a single valid/ready output register in round-robin order.
//
// Ports:
//   clk    system clock, rising edge.
//   reset  asynchronous, active-high reset.
//   bus    edge_event_arbiter_if.master (inputs, event output, status, debug).
module edge_event_arbiter #(
    parameter int N        = 4,
    parameter int DB_TICKS = 20
) (
    input  logic                clk,
    input  logic                reset,
    edge_event_arbiter_if.master bus
);
    localparam int ID_W = (N > 1) ? $clog2(N) : 1;
    localparam int CW   = $clog2(DB_TICKS);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DB_TICKS - 1);

    typedef enum logic [1:0] {
        ST_LOW     = 2'd0,
        ST_LOCK_HI = 2'd1,
        ST_HIGH    = 2'd2,
        ST_LOCK_LO = 2'd3
    } db_state_t;

    logic [N-1:0]    sync1_q, sync_q;
    db_state_t       state_q [N];
    db_state_t       state_d [N];
    logic [CW-1:0]   cnt_q [N];
    logic [CW-1:0]   cnt_d [N];
    logic [N-1:0]    cap, cap_rise;

    logic [N-1:0]    pending_q, pending_d;
    logic [N-1:0]    pol_q, pol_d;
    logic [N-1:0]    overflow_q, overflow_d;
    logic [N-1:0]    grant;

    logic            valid_q, rise_q;
    logic [ID_W-1:0] id_q, rr_q, rr_d;
    logic [ID_W-1:0] winner, idx_w;
    logic            found, load;

    // Debounce FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= ST_LOW;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Debounce FSM next state. An edge is reported on the first synchronized
    // sample that differs from the settled level; the lock states then ignore
    // the input for exactly DB_TICKS clocks so bounce cannot re-trigger.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            state_d[i]  = state_q[i];
            cnt_d[i]    = cnt_q[i];
            cap[i]      = 1'b0;
            cap_rise[i] = 1'b0;
            case (state_q[i])
                ST_LOW: begin
                    if (sync_q[i]) begin
                        state_d[i]  = ST_LOCK_HI;
                        cnt_d[i]    = CNT_LOAD;
                        cap[i]      = 1'b1;
                        cap_rise[i] = 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (!sync_q[i]) begin
                        state_d[i] = ST_LOCK_LO;
                        cnt_d[i]   = CNT_LOAD;
                        cap[i]     = 1'b1;
                    end
                end
                ST_LOCK_HI: begin
                    if (cnt_q[i] == '0) state_d[i] = ST_HIGH;
                    else                cnt_d[i]   = cnt_q[i] - 1'b1;
                end
                ST_LOCK_LO: begin
                    if (cnt_q[i] == '0) state_d[i] = ST_LOW;
                    else                cnt_d[i]   = cnt_q[i] - 1'b1;
                end
                default: state_d[i] = ST_LOW;
            endcase
        end
    end

    // Round-robin pick: first pending channel at or above rr_q, wrapping.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx_w  = '0;
        for (int k = 0; k < N; k++) begin
            idx_w = ID_W'((int'(rr_q) + k) % N);
            if (!found && pending_q[idx_w]) begin
                winner = idx_w;
                found  = 1'b1;
            end
        end
        load = found && (!valid_q || bus.evt_ready);
        rr_d = (int'(winner) == N - 1) ? '0 : winner + ID_W'(1);
    end

    // Pending/overflow bookkeeping. A capture in the same cycle as the grant
    // of that channel refills the slot instead of overflowing it.
    always_comb begin
        pending_d  = pending_q;
        pol_d      = pol_q;
        overflow_d = overflow_q & ~bus.clr_overflow;
        for (int i = 0; i < N; i++) begin
            grant[i] = load && (winner == ID_W'(i));
            if (grant[i]) pending_d[i] = 1'b0;
            if (cap[i]) begin
                if (pending_q[i] && !grant[i]) begin
                    overflow_d[i] = 1'b1;   // set wins over a same-cycle clear
                end else begin
                    pending_d[i] = 1'b1;
                    pol_d[i]     = cap_rise[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= '0;
            sync_q     <= '0;
            pending_q  <= '0;
            pol_q      <= '0;
            overflow_q <= '0;
            valid_q    <= 1'b0;
            id_q       <= '0;
            rise_q     <= 1'b0;
            rr_q       <= '0;
        end else begin
            sync1_q    <= bus.in;
            sync_q     <= sync1_q;
            pending_q  <= pending_d;
            pol_q      <= pol_d;
            overflow_q <= overflow_d;
            if (load) begin
                valid_q <= 1'b1;
                id_q    <= winner;
                rise_q  <= pol_q[winner];
                rr_q    <= rr_d;
            end else if (bus.evt_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.dbg_state = '0;
        for (int i = 0; i < N; i++) begin
            bus.dbg_state[2*i +: 2] = state_q[i];
        end
    end

    assign bus.evt_valid  = valid_q;
    assign bus.evt_id     = id_q;
    assign bus.evt_rise   = rise_q;
    assign bus.pending    = pending_q;
    assign bus.overflow   = overflow_q;
    assign bus.dbg_rr_ptr = rr_q;
endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter with N=4, DB_TICKS=8. Inputs change
// on the falling clock edge; outputs are sampled on the falling edge.
module tb_edge_event_arbiter;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    edge_event_arbiter_if #(.N(4)) bus ();

    edge_event_arbiter #(.N(4), .DB_TICKS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        reset = 1'b1;
        bus.in = '0;
        bus.evt_ready = 1'b0;
        bus.clr_overflow = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.in = '0;
        bus.evt_ready = 1'b0;
        bus.clr_overflow = '0;
        @(negedge clk);
        n_cmp++; if (bus.evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.evt_valid); end
        n_cmp++; if (bus.evt_id !== 2'd0) begin n_fail++; $display("FAIL reset_id: got %0d want 0", bus.evt_id); end
        n_cmp++; if (bus.evt_rise !== 1'b0) begin n_fail++; $display("FAIL reset_rise: got %b want 0", bus.evt_rise); end
        n_cmp++; if (bus.pending !== 4'b0000) begin n_fail++; $display("FAIL reset_pending: got %b want 0000", bus.pending); end
        n_cmp++; if (bus.overflow !== 4'b0000) begin n_fail++; $display("FAIL reset_overflow: got %b want 0000", bus.overflow); end
        n_cmp++; if (bus.dbg_state !== 8'h00) begin n_fail++; $display("FAIL reset_state: got %h want 00", bus.dbg_state); end
        n_cmp++; if (bus.dbg_rr_ptr !== 2'd0) begin n_fail++; $display("FAIL reset_rr: got %0d want 0", bus.dbg_rr_ptr); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Scenario 1: single rise, exact latency, one-clock valid with ready=1.
    task automatic test_single_rise();
        do_reset();
        bus.evt_ready = 1'b1;
        bus.in = 4'b0100;            // sampled at edge k
        repeat (3) @(negedge clk);   // after edge k+2
        n_cmp++; if (bus.pending !== 4'b0100) begin n_fail++; $display("FAIL s1_pending_k2: got %b want 0100", bus.pending); end
        n_cmp++; if (bus.evt_valid !== 1'b0) begin n_fail++; $display("FAIL s1_valid_k2: got %b want 0", bus.evt_valid); end
        @(negedge clk);              // after edge k+3
        n_cmp++; if (bus.evt_valid !== 1'b1) begin n_fail++; $display("FAIL s1_valid_k3: got %b want 1", bus.evt_valid); end
        n_cmp++; if (bus.evt_id !== 2'd2) begin n_fail++; $display("FAIL s1_id: got %0d want 2", bus.evt_id); end
        n_cmp++; if (bus.evt_rise !== 1'b1) begin n_fail++; $display("FAIL s1_rise: got %b want 1", bus.evt_rise); end
        n_cmp++; if (bus.pending !== 4'b0000) begin n_fail++; $display("FAIL s1_pending_k3: got %b want 0000", bus.pending); end
        @(negedge clk);              // after edge k+4
        n_cmp++; if (bus.evt_valid !== 1'b0) begin n_fail++; $display("FAIL s1_valid_k4: got %b want 0", bus.evt_valid); end
        n_cmp++; if (bus.dbg_rr_ptr !== 2'd3) begin n_fail++; $display("FAIL s1_rr: got %0d want 3", bus.dbg_rr_ptr); end
    endtask

    // Scenario 2: bounce on ch0 yields exactly one rise event.
    task automatic test_bounce();
        int n_rise;
        int n_fall;
        n_rise = 0;
        n_fall = 0;
        do_reset();
        bus.evt_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (bus.evt_valid === 1'b1) begin
                if (bus.evt_rise === 1'b1) n_rise++;
                else n_fall++;
            end
            bus.in[0] = (c < 6) ? ((c % 2) == 0) : 1'b1;
            @(negedge clk);
        end
        n_cmp++; if (n_rise != 1) begin n_fail++; $display("FAIL s2_rise_count: got %0d want 1", n_rise); end
        n_cmp++; if (n_fall != 0) begin n_fail++; $display("FAIL s2_fall_count: got %0d want 0", n_fall); end
        n_cmp++; if (bus.dbg_state[1:0] !== 2'd2) begin n_fail++; $display("FAIL s2_state: got %0d want 2", bus.dbg_state[1:0]); end
    endtask

    // Scenario 3: simultaneous rises issue back-to-back in round-robin order.
    task automatic test_back_to_back();
        do_reset();
        bus.evt_ready = 1'b1;
        bus.in = 4'b1111;
        repeat (3) @(negedge clk);   // after edge k+2
        n_cmp++; if (bus.pending !== 4'b1111) begin n_fail++; $display("FAIL s3_pending: got %b want 1111", bus.pending); end
        for (int e = 0; e < 4; e++) begin
            @(negedge clk);          // after edge k+3+e
            n_cmp++; if (bus.evt_valid !== 1'b1 || bus.evt_id !== 2'(e) || bus.evt_rise !== 1'b1) begin
                n_fail++; $display("FAIL s3_event%0d: got valid=%b id=%0d rise=%b want valid=1 id=%0d rise=1", e, bus.evt_valid, bus.evt_id, bus.evt_rise, e);
            end
        end
        n_cmp++; if (bus.dbg_rr_ptr !== 2'd0) begin n_fail++; $display("FAIL s3_rr: got %0d want 0", bus.dbg_rr_ptr); end
        @(negedge clk);
        n_cmp++; if (bus.evt_valid !== 1'b0) begin n_fail++; $display("FAIL s3_valid_end: got %b want 0", bus.evt_valid); end
    endtask

    // Scenario 4: held output, one queued fall, third edge dropped.
    task automatic test_overflow();
        int n_ev;
        logic [3:0] ev_id [4];
        logic       ev_rise [4];
        n_ev = 0;
        do_reset();
        bus.evt_ready = 1'b0;
        bus.in[1] = 1'b1;
        repeat (8) @(negedge clk);
        bus.in[1] = 1'b0;
        repeat (8) @(negedge clk);
        n_cmp++; if (bus.evt_valid !== 1'b1 || bus.evt_id !== 2'd1 || bus.evt_rise !== 1'b1) begin
            n_fail++; $display("FAIL s4_hold1: got valid=%b id=%0d rise=%b want 1/1/1", bus.evt_valid, bus.evt_id, bus.evt_rise);
        end
        n_cmp++; if (bus.pending !== 4'b0010) begin n_fail++; $display("FAIL s4_pending1: got %b want 0010", bus.pending); end
        n_cmp++; if (bus.overflow !== 4'b0000) begin n_fail++; $display("FAIL s4_ovf1: got %b want 0000", bus.overflow); end
        bus.in[1] = 1'b1;
        repeat (8) @(negedge clk);
        n_cmp++; if (bus.overflow !== 4'b0010) begin n_fail++; $display("FAIL s4_ovf2: got %b want 0010", bus.overflow); end
        n_cmp++; if (bus.evt_valid !== 1'b1 || bus.evt_id !== 2'd1 || bus.evt_rise !== 1'b1) begin
            n_fail++; $display("FAIL s4_hold2: got valid=%b id=%0d rise=%b want 1/1/1", bus.evt_valid, bus.evt_id, bus.evt_rise);
        end
        bus.evt_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (bus.evt_valid === 1'b1) begin
                if (n_ev < 4) begin
                    ev_id[n_ev]   = {2'b00, bus.evt_id};
                    ev_rise[n_ev] = bus.evt_rise;
                end
                n_ev++;
            end
            @(negedge clk);
        end
        n_cmp++; if (n_ev != 2) begin n_fail++; $display("FAIL s4_event_count: got %0d want 2", n_ev); end
        if (n_ev >= 2) begin
            n_cmp++; if (ev_id[0] !== 4'd1 || ev_rise[0] !== 1'b1) begin n_fail++; $display("FAIL s4_first: got id=%0d rise=%b want id=1 rise=1", ev_id[0], ev_rise[0]); end
            n_cmp++; if (ev_id[1] !== 4'd1 || ev_rise[1] !== 1'b0) begin n_fail++; $display("FAIL s4_second: got id=%0d rise=%b want id=1 rise=0", ev_id[1], ev_rise[1]); end
        end
    endtask

    // Scenario 5: reset while an event is held and two are pending.
    task automatic test_reset_mid();
        int seen;
        seen = 0;
        do_reset();
        bus.evt_ready = 1'b0;
        bus.in[1] = 1'b1;
        repeat (5) @(negedge clk);
        bus.in[0] = 1'b1;
        bus.in[2] = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++; if (bus.pending !== 4'b0101 || bus.evt_valid !== 1'b1 || bus.evt_id !== 2'd1) begin
            n_fail++; $display("FAIL s5_setup: got pending=%b valid=%b id=%0d want 0101/1/1", bus.pending, bus.evt_valid, bus.evt_id);
        end
        reset = 1'b1;
        bus.in = '0;
        #1;
        n_cmp++; if (bus.evt_valid !== 1'b0 || bus.pending !== 4'b0000 || bus.overflow !== 4'b0000 || bus.evt_id !== 2'd0 || bus.evt_rise !== 1'b0) begin
            n_fail++; $display("FAIL s5_async: got valid=%b pending=%b ovf=%b id=%0d rise=%b want all 0", bus.evt_valid, bus.pending, bus.overflow, bus.evt_id, bus.evt_rise);
        end
        @(negedge clk);
        reset = 1'b0;
        bus.evt_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.evt_valid !== 1'b0 || bus.pending !== 4'b0000) seen++;
        end
        n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL s5_no_events: got %0d active cycles want 0", seen); end
    endtask

    // Input already high when reset releases.
    task automatic test_high_at_reset();
        reset = 1'b1;
        bus.in = 4'b1000;
        bus.evt_ready = 1'b1;
        bus.clr_overflow = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;                // next posedge is the first sampling edge k
        repeat (3) @(negedge clk);   // after edge k+2
        n_cmp++; if (bus.evt_valid !== 1'b0 || bus.pending !== 4'b1000) begin
            n_fail++; $display("FAIL rel_k2: got valid=%b pending=%b want 0/1000", bus.evt_valid, bus.pending);
        end
        @(negedge clk);              // after edge k+3
        n_cmp++; if (bus.evt_valid !== 1'b1 || bus.evt_id !== 2'd3 || bus.evt_rise !== 1'b1) begin
            n_fail++; $display("FAIL rel_k3: got valid=%b id=%0d rise=%b want 1/3/1", bus.evt_valid, bus.evt_id, bus.evt_rise);
        end
    endtask

    // Scenario 6: overflow set beats a same-cycle clear; a lone clear works.
    task automatic test_clr_overflow();
        do_reset();
        bus.evt_ready = 1'b0;
        bus.in[0] = 1'b1;
        repeat (10) @(negedge clk);
        bus.in[1] = 1'b1;
        repeat (12) @(negedge clk);
        n_cmp++; if (bus.pending !== 4'b0010) begin n_fail++; $display("FAIL s6_pending: got %b want 0010", bus.pending); end
        bus.in[1] = 1'b0;            // sampled at edge k, captured at edge k+2
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (bus.overflow !== 4'b0000) begin n_fail++; $display("FAIL s6_ovf_before: got %b want 0000", bus.overflow); end
        bus.clr_overflow = 4'b0010;  // active across edge k+2
        @(negedge clk);
        bus.clr_overflow = 4'b0000;
        n_cmp++; if (bus.overflow !== 4'b0010) begin n_fail++; $display("FAIL s6_set_wins: got %b want 0010", bus.overflow); end
        bus.clr_overflow = 4'b0010;
        @(negedge clk);
        bus.clr_overflow = 4'b0000;
        n_cmp++; if (bus.overflow !== 4'b0000) begin n_fail++; $display("FAIL s6_clear: got %b want 0000", bus.overflow); end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        test_reset();
        test_single_rise();
        test_bounce();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        test_high_at_reset();
        test_clr_overflow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
